// File: rtl/ultrasonic_sensor_scheduler_if.sv
// Handshake bundle between the ultrasonic scheduler and its controller/sensor side.
// The scheduler is the slave; whoever drives enable/echo is the master.
interface ultrasonic_sensor_scheduler_if #(
    parameter int n_sensors    = 4,
    parameter int max_range_cm = 400
);
    localparam int dw = $clog2(max_range_cm + 1);
    localparam int iw = (n_sensors > 1) ? $clog2(n_sensors) : 1;

    logic                    enable;
    logic [n_sensors-1:0]    trig;
    logic [n_sensors-1:0]    echo;
    logic [n_sensors*dw-1:0] distance_cm;
    logic [n_sensors-1:0]    timeout;
    logic                    done;
    logic [iw-1:0]           done_id;
    logic                    busy;

    modport master (
        output enable, echo,
        input  trig, distance_cm, timeout, done, done_id, busy
    );

    modport slave (
        input  enable, echo,
        output trig, distance_cm, timeout, done, done_id, busy
    );
endinterface

// File: rtl/ultrasonic_sensor_scheduler.sv
// Round-robin HC-SR04 scheduler: one shared trigger/echo-timing engine serving
// n_sensors sensors, one result register per sensor.
module ultrasonic_sensor_scheduler #(
    parameter int clk_frequency = 50000000,
    parameter int n_sensors     = 4,
    parameter int max_range_cm  = 400,
    parameter int guard_ms      = 60
) (
    input logic clk,
    input logic rst,
    ultrasonic_sensor_scheduler_if.slave bus
);
    localparam int trig_cycles  = 10 * (clk_frequency / 1000000);
    localparam int cm_cycles    = clk_frequency * 2 / 343 / 100;
    localparam int arm_timeout  = 2 * (clk_frequency / 1000);
    localparam int guard_cycles = guard_ms * (clk_frequency / 1000);
    localparam int dw           = $clog2(max_range_cm + 1);
    localparam int iw           = (n_sensors > 1) ? $clog2(n_sensors) : 1;

    localparam int max_ta  = (trig_cycles > arm_timeout) ? trig_cycles : arm_timeout;
    localparam int max_cg  = (cm_cycles > guard_cycles) ? cm_cycles : guard_cycles;
    localparam int cnt_max = (max_ta > max_cg) ? max_ta : max_cg;
    localparam int cw      = $clog2(cnt_max + 1);

    typedef enum logic [2:0] {IDLE, TRIG, ARM, MEASURE, GUARD} state_t;

    state_t                          state;
    logic [n_sensors-1:0]            echo_s1, echo_s2;
    logic                            echo_d;
    logic [iw-1:0]                   cur;
    logic [cw-1:0]                   cnt;
    logic [dw-1:0]                   cm_cnt;
    logic [n_sensors-1:0][dw-1:0]    dist_q;
    logic [n_sensors-1:0]            to_q;
    logic [n_sensors-1:0]            trig_q;
    logic                            done_q;
    logic [iw-1:0]                   done_id_q;
    logic                            busy_q;

    logic          echo_cur, echo_rise, echo_fall;
    logic [iw-1:0] cur_next;
    logic          cm_wrap;
    logic [dw-1:0] cm_final;
    logic          wr_en, wr_to;
    logic [dw-1:0] wr_val;

    function automatic logic [n_sensors-1:0] onehot(input logic [iw-1:0] idx);
        logic [n_sensors-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign echo_cur  = echo_s2[cur];
    assign echo_rise = echo_cur & ~echo_d;
    assign echo_fall = ~echo_cur & echo_d;
    assign cur_next  = (cur == iw'(n_sensors - 1)) ? '0 : cur + 1'b1;
    assign cm_wrap   = (cnt == cw'(cm_cycles - 1));
    // The fall-sampling clock itself counts toward the width, so a pulse of
    // exactly k*cm_cycles clocks reads as k cm.
    assign cm_final  = cm_cnt + dw'(cm_wrap);

    always_comb begin
        wr_en  = 1'b0;
        wr_val = dw'(max_range_cm);
        wr_to  = 1'b1;
        case (state)
            ARM: wr_en = !echo_rise && (cnt == cw'(arm_timeout - 1));
            MEASURE: begin
                if (echo_fall) begin
                    wr_en  = 1'b1;
                    wr_val = cm_final;
                    wr_to  = 1'b0;
                end else if (cm_wrap && (cm_cnt == dw'(max_range_cm - 1))) begin
                    wr_en = 1'b1;
                end
            end
            default: wr_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            echo_s1 <= '0;
            echo_s2 <= '0;
        end else begin
            echo_s1 <= bus.echo;
            echo_s2 <= echo_s1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dist_q    <= '0;
            to_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            done_q <= wr_en;
            if (wr_en) begin
                dist_q[cur] <= wr_val;
                to_q[cur]   <= wr_to;
                done_id_q   <= cur;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cur    <= '0;
            cnt    <= '0;
            cm_cnt <= '0;
            echo_d <= 1'b0;
            trig_q <= '0;
            busy_q <= 1'b0;
        end else begin
            echo_d <= echo_cur;
            case (state)
                IDLE: begin
                    if (bus.enable) begin
                        state  <= TRIG;
                        cnt    <= '0;
                        trig_q <= onehot(cur);
                        busy_q <= 1'b1;
                    end
                end
                TRIG: begin
                    if (cnt == cw'(trig_cycles - 1)) begin
                        trig_q <= '0;
                        cnt    <= '0;
                        state  <= ARM;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ARM: begin
                    if (echo_rise) begin
                        state  <= MEASURE;
                        cnt    <= '0;
                        cm_cnt <= '0;
                    end else if (wr_en) begin
                        state <= GUARD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MEASURE: begin
                    if (wr_en) begin
                        state <= GUARD;
                        cnt   <= '0;
                    end else if (cm_wrap) begin
                        cnt    <= '0;
                        cm_cnt <= cm_cnt + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GUARD: begin
                    if (cnt == cw'(guard_cycles - 1)) begin
                        cur <= cur_next;
                        cnt <= '0;
                        if (bus.enable) begin
                            state  <= TRIG;
                            trig_q <= onehot(cur_next);
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.trig        = trig_q;
    assign bus.distance_cm = dist_q;
    assign bus.timeout     = to_q;
    assign bus.done        = done_q;
    assign bus.done_id     = done_id_q;
    assign bus.busy        = busy_q;
endmodule

// File: doc/ultrasonic_sensor_scheduler.md
ULTRASONIC_SENSOR_SCHEDULER -- requirements
Module: ultrasonic_sensor_scheduler

Interface
REQ-001 Parameter clk_frequency, default 50000000, clk rate in Hz.
REQ-002 Parameter n_sensors, default 4, number of HC-SR04 sensors sharing one measurement engine; range 1..16.
REQ-003 Parameter max_range_cm, default 400, saturation and timeout distance in cm.
REQ-004 Parameter guard_ms, default 60, quiet time after each measurement before the next trigger.
REQ-005 Localparams:
  - trig_cycles = 10 * (clk_frequency / 1000000).
  - cm_cycles = clk_frequency * 2 / 343 / 100.
  - arm_timeout = 2 * (clk_frequency / 1000).
  - guard_cycles = guard_ms * (clk_frequency / 1000).
  - dw = $clog2(max_range_cm + 1).
  - iw = max(1, $clog2(n_sensors)).
REQ-006 clk  input  1  system clock.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 enable  input  1  run the round-robin measurement schedule while high.
REQ-009 trig  output  n_sensors  per-sensor trigger, at most one bit high at any time.
REQ-010 echo  input  n_sensors  per-sensor echo, asynchronous to clk.
REQ-011 distance_cm  output  n_sensors*dw  last result per sensor; sensor k occupies bits [k*dw +: dw].
REQ-012 timeout  output  n_sensors  per-sensor flag; set when that sensor's last measurement timed out.
REQ-013 done  output  1  one-cycle strobe when a result is written.
REQ-014 done_id  output  iw  index of the sensor written, valid while done is high.
REQ-015 busy  output  1  high in every state except IDLE.

Function
REQ-016 Each echo bit shall pass a 2-flop synchronizer. Only the synchronized echo of the current index cur is observed; all other echo bits are ignored.
REQ-017 The FSM shall have the states IDLE, TRIG, ARM, MEASURE and GUARD.
REQ-018 IDLE: when enable=1, go to TRIG on the next clk, clear the cycle counter and hold cur. When enable=0, stay in IDLE.
REQ-019 TRIG: drive trig[cur]=1 for exactly trig_cycles clocks, then go to ARM. trig shall be a registered output.
REQ-020 ARM: wait for a synchronized rising edge of echo[cur], then go to MEASURE with cycle counter=0 and cm counter=0.
REQ-021 ARM timeout: if no rising edge arrives within arm_timeout clocks, write distance=max_range_cm and timeout[cur]=1, pulse done, and go to GUARD.
REQ-022 MEASURE: the cycle counter counts clocks. When it reaches cm_cycles-1 it wraps to 0 and the cm counter increments.
REQ-023 MEASURE echo fall: on a synchronized falling edge of echo[cur], write distance=cm counter and timeout[cur]=0, pulse done with done_id=cur, and go to GUARD.
REQ-024 MEASURE saturation: if the cm counter reaches max_range_cm before echo falls, write max_range_cm and timeout[cur]=1, pulse done, and go to GUARD. No cm value greater than max_range_cm is ever written.
REQ-025 Echo already high on entry to ARM shall not count as a rising edge; the FSM waits for a low-to-high transition.
REQ-026 GUARD: wait guard_cycles clocks, then advance cur (n_sensors-1 wraps to 0).
  - enable=1: go to TRIG.
  - enable=0: go to IDLE.
REQ-027 Deasserting enable mid-cycle shall not abort the current cycle; the cycle completes through GUARD.
REQ-028 Writing a result changes only the entry for cur; all other distance_cm and timeout entries hold their values.
REQ-029 Latency: done shall occur exactly 3 clocks after the echo[cur] falling edge at the pin (2 synchronizer clocks + 1 registered write).
REQ-030 All counters shall be sized to hold their maximum terminal value without overflow.

Reset
REQ-031 On rst=1, regardless of state or clk, the block shall immediately return to:
  - state IDLE, cur=0, all counters 0;
  - trig=0, distance_cm=0, timeout=0, done=0, done_id=0, busy=0;
  - synchronizers 0.
REQ-032 Reset asserted mid-TRIG shall drop trig within the same reset assertion, with no clock edge required.

Verification (clk_frequency=1000000, n_sensors=4, max_range_cm=400, guard_ms=1, so cm_cycles=58, trig_cycles=10)
REQ-033 Single echo: enable=1, echo[0] high for 58*100 clocks starting 20 clocks after trig falls.
  - Required: trig[0] high exactly 10 clocks.
  - Required: done with done_id=0 and distance[0]=100, timeout[0]=0.
REQ-034 No echo: echo[1] never rises.
  - Required: done 2000 clocks after ARM entry, distance[1]=400, timeout[1]=1.
REQ-035 Stuck-high echo: echo[2] held high for 30000 clocks.
  - Required: saturation at 400 cm, timeout[2]=1.
  - Required: result written 58*400 clocks after the rising edge.
REQ-036 Rotation: run 5 cycles with all sensors responding.
  - Required: trig order 0,1,2,3,0.
  - Required: each trig is preceded by 1000 GUARD clocks.
  - Required: other sensors' entries are never disturbed.
REQ-037 Cross-talk: pulse echo[3] while cur=0.
  - Required: no effect on any result.
  - Required: rst asserted mid-MEASURE sets all outputs to 0 asynchronously, and the schedule restarts at cur=0.
